// File: rtl/core_lsu_pkg.sv
// Shared types and constants for the core_lsu load/store unit.
// Holds the funct3 encodings, FSM state type and lane-offset helpers.
package core_lsu_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int MEM_TRANSFER_WIDTH = 4;
    localparam int REG_ADDR_WIDTH     = 5;

    localparam logic [2:0] LS_OP_B  = 3'b000;
    localparam logic [2:0] LS_OP_H  = 3'b001;
    localparam logic [2:0] LS_OP_W  = 3'b010;
    localparam logic [2:0] LS_OP_BU = 3'b100;
    localparam logic [2:0] LS_OP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_REQ    = 2'd1,
        LSU_RDWAIT = 2'd2
    } lsu_state_e;

    // Byte offset of the naturally aligned container the access lands in.
    function automatic logic [1:0] lane_offset(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op[1:0])
            2'b00:   return addr_lo;
            2'b01:   return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic: byte enables and store-data replication on the way out,
// load-data extraction and sign/zero extension on the way back.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [2:0]                    ls_op,
    input  logic [1:0]                    addr_lo,
    input  logic [DATA_WIDTH-1:0]         store_data,
    input  logic [DATA_WIDTH-1:0]         rdata,
    output logic [MEM_TRANSFER_WIDTH-1:0] be,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         load_data
);

    logic [1:0]            offset;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        offset  = lane_offset(ls_op, addr_lo);
        shifted = rdata >> {offset, 3'b000};

        case (ls_op[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase

        case (ls_op)
            LS_OP_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LS_OP_BU: load_data = {24'd0, shifted[7:0]};
            LS_OP_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            LS_OP_HU: load_data = {16'd0, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit between M and W: bus handshake FSM, timeout abort and W register.
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          m_valid_i,
    input  logic                          m_load_i,
    input  logic                          m_store_i,
    input  logic [2:0]                    m_ls_op_i,
    input  logic [31:0]                   m_addr_i,
    input  logic [DATA_WIDTH-1:0]         m_wdata_i,
    input  logic [DATA_WIDTH-1:0]         m_regfile_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0]     m_regfile_waddr_i,
    input  logic                          m_regfile_wr_i,
    output logic                          stall_o,
    output logic                          data_req_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    output logic                          data_wr_o,
    output logic [ADDR_WIDTH-1:0]         data_addr_o,
    output logic [DATA_WIDTH-1:0]         data_wdata_o,
    output logic [MEM_TRANSFER_WIDTH-1:0] data_be_o,
    input  logic [DATA_WIDTH-1:0]         data_rdata_i,
    output logic                          w_valid_o,
    output logic [REG_ADDR_WIDTH-1:0]     w_regfile_waddr_o,
    output logic                          w_regfile_wr_o,
    output logic [DATA_WIDTH-1:0]         w_regfile_wdata_o,
    output logic                          w_bus_err_o,
    output logic                          w_misaligned_o
);

    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LIMIT =
        TMO_CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_e              state_q, state_d;
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt_q;
    logic                    access, is_load, is_store, misaligned, issue;
    logic                    complete, abort, timeout_hit;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    unused_addr_hi;

    assign access   = m_valid_i & (m_load_i | m_store_i);
    assign is_load  = m_load_i;
    assign is_store = m_store_i & ~m_load_i;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = access & is_misaligned(m_ls_op_i, m_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign issue          = access & ~misaligned;
    assign unused_addr_hi = ^(m_addr_i >> ADDR_WIDTH);

    assign data_addr_o = {m_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign data_wr_o   = issue & is_store;

    core_lsu_align u_align (
        .ls_op      (m_ls_op_i),
        .addr_lo    (m_addr_i[1:0]),
        .store_data (m_wdata_i),
        .rdata      (data_rdata_i),
        .be         (data_be_o),
        .wdata      (data_wdata_o),
        .load_data  (load_data)
    );

    // The counter holds the number of cycles already spent outside IDLE.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != LSU_IDLE) && (tmo_cnt_q == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (issue) begin
                    if (!data_gnt_i) begin
                        state_d = LSU_REQ;
                    end else if (is_load) begin
                        state_d = LSU_RDWAIT;
                    end
                end
            end
            LSU_REQ: begin
                if (data_gnt_i) begin
                    state_d = is_load ? LSU_RDWAIT : LSU_IDLE;
                end else if (timeout_hit) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_RDWAIT: begin
                if (data_rvalid_i || timeout_hit) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // A response arriving in the timeout cycle still completes the access.
    always_comb begin
        data_req_o = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                data_req_o = issue;
                complete   = misaligned | (issue & is_store & data_gnt_i);
            end
            LSU_REQ: begin
                data_req_o = 1'b1;
                complete   = is_store & data_gnt_i;
                abort      = ~data_gnt_i & timeout_hit;
            end
            LSU_RDWAIT: begin
                complete = data_rvalid_i;
                abort    = ~data_rvalid_i & timeout_hit;
            end
            default: ;
        endcase
        stall_o = access & ~(complete | abort);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == LSU_IDLE || state_d == LSU_IDLE) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid_o         <= 1'b0;
            w_regfile_waddr_o <= '0;
            w_regfile_wr_o    <= 1'b0;
            w_regfile_wdata_o <= '0;
            w_bus_err_o       <= 1'b0;
            w_misaligned_o    <= 1'b0;
        end else if (stall_o || !m_valid_i) begin
            w_valid_o      <= 1'b0;
            w_regfile_wr_o <= 1'b0;
            w_bus_err_o    <= 1'b0;
            w_misaligned_o <= 1'b0;
        end else begin
            w_valid_o         <= 1'b1;
            w_regfile_waddr_o <= m_regfile_waddr_i;
            w_regfile_wr_o    <= m_regfile_wr_i & ~abort & ~misaligned;
            w_regfile_wdata_o <= (access & is_load) ? load_data : m_regfile_rd_i;
            w_bus_err_o       <= abort;
            w_misaligned_o    <= misaligned;
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed and random accesses against a transaction-level
// model, plus a short-timeout instance for the abort path.
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid_i = 1'b0, m_load_i = 1'b0, m_store_i = 1'b0;
    logic [2:0]  m_ls_op_i = 3'd0;
    logic [31:0] m_addr_i = '0, m_wdata_i = '0, m_regfile_rd_i = '0;
    logic [4:0]  m_regfile_waddr_i = '0;
    logic        m_regfile_wr_i = 1'b0;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;

    logic        stall_o, data_req_o, data_wr_o, w_valid_o, w_regfile_wr_o, w_bus_err_o, w_misaligned_o;
    logic [15:0] data_addr_o;
    logic [31:0] data_wdata_o, w_regfile_wdata_o;
    logic [3:0]  data_be_o;
    logic [4:0]  w_regfile_waddr_o;

    logic        t_stall, t_req, t_wr, t_w_valid, t_w_wr, t_w_err, t_w_mis;
    logic [15:0] t_addr;
    logic [31:0] t_wdata, t_w_wdata;
    logic [3:0]  t_be;
    logic [4:0]  t_w_waddr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid_i(m_valid_i), .m_load_i(m_load_i), .m_store_i(m_store_i),
        .m_ls_op_i(m_ls_op_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_regfile_rd_i(m_regfile_rd_i), .m_regfile_waddr_i(m_regfile_waddr_i),
        .m_regfile_wr_i(m_regfile_wr_i), .stall_o(stall_o), .data_req_o(data_req_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_wr_o(data_wr_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_rdata_i(data_rdata_i), .w_valid_o(w_valid_o),
        .w_regfile_waddr_o(w_regfile_waddr_o), .w_regfile_wr_o(w_regfile_wr_o),
        .w_regfile_wdata_o(w_regfile_wdata_o), .w_bus_err_o(w_bus_err_o),
        .w_misaligned_o(w_misaligned_o)
    );

    core_lsu #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(4), .TMO_CNT_WIDTH(8)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .m_valid_i(m_valid_i), .m_load_i(m_load_i), .m_store_i(m_store_i),
        .m_ls_op_i(m_ls_op_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_regfile_rd_i(m_regfile_rd_i), .m_regfile_waddr_i(m_regfile_waddr_i),
        .m_regfile_wr_i(m_regfile_wr_i), .stall_o(t_stall), .data_req_o(t_req),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_wr_o(t_wr),
        .data_addr_o(t_addr), .data_wdata_o(t_wdata), .data_be_o(t_be),
        .data_rdata_i(data_rdata_i), .w_valid_o(t_w_valid),
        .w_regfile_waddr_o(t_w_waddr), .w_regfile_wr_o(t_w_wr),
        .w_regfile_wdata_o(t_w_wdata), .w_bus_err_o(t_w_err),
        .w_misaligned_o(t_w_mis)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // kind: 0 load, 1 store, 2 non-memory instruction.
    // g = cycles before grant, r = extra cycles between grant and rvalid.
    task automatic applyStimulus(input int kind, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rd,
                                 input logic [4:0] waddr, input logic wr, input int g, input int r,
                                 input logic [31:0] rdata, input bit noise);
        int          nbytes, off, done_k;
        bit          mem, ld, mis;
        logic [31:0] e_wd, e_res, mask;
        logic [3:0]  e_be;

        mem    = (kind != 2);
        ld     = (kind == 0);
        nbytes = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]) / nbytes * nbytes;
        e_be   = 4'((1 << nbytes) - 1) << off;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = sdata[8*(i % nbytes) +: 8];
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
        e_res  = (rdata >> (8 * off)) & mask;
        if (op[2] == 1'b0 && nbytes < 4 && e_res[8*nbytes-1]) e_res = e_res | ~mask;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = mem && (int'(addr[1:0]) % nbytes != 0);
`endif
        done_k = (!mem || mis) ? 0 : (ld ? g + 1 + r : g);

        for (int k = 0; k <= done_k; k++) begin
            @(negedge clk);
            m_valid_i         = 1'b1;
            m_load_i          = ld;
            m_store_i         = (kind == 1);
            m_ls_op_i         = op;
            m_addr_i          = addr;
            m_wdata_i         = sdata;
            m_regfile_rd_i    = rd;
            m_regfile_waddr_i = waddr;
            m_regfile_wr_i    = wr;
            data_gnt_i        = mem && !mis && (k == g);
            data_rvalid_i     = (ld && !mis && k == g + 1 + r) || (noise && k <= g);
            data_rdata_i      = (ld && k == g + 1 + r) ? rdata : $urandom;
            #2;
            checkOutput("stall", 32'(stall_o), 32'(k < done_k));
            checkOutput("req", 32'(data_req_o), 32'(mem && !mis && k <= g));
            if (k == 0) begin
                checkOutput("bus_wr", 32'(data_wr_o), 32'(mem && !ld && !mis));
                if (mem && !mis) begin
                    checkOutput("bus_be", 32'(data_be_o), 32'(e_be));
                    checkOutput("bus_addr", 32'(data_addr_o), 32'(addr[15:0] & 16'hFFFC));
                    if (!ld) checkOutput("bus_wdata", data_wdata_o, e_wd);
                end
            end
            @(posedge clk);
            #1;
            if (k < done_k) checkOutput("bubble", 32'(w_valid_o), 32'd0);
        end

        checkOutput("w_valid", 32'(w_valid_o), 32'd1);
        checkOutput("w_waddr", 32'(w_regfile_waddr_o), 32'(waddr));
        checkOutput("w_wr", 32'(w_regfile_wr_o), 32'(wr && !mis));
        if (!mis) checkOutput("w_wdata", w_regfile_wdata_o, ld ? e_res : rd);
        checkOutput("w_bus_err", 32'(w_bus_err_o), 32'd0);
        checkOutput("w_misaligned", 32'(w_misaligned_o), 32'(mis));
    endtask

    task automatic applyIdle(input bit stray_rvalid);
        @(negedge clk);
        m_valid_i     = 1'b0;
        m_load_i      = 1'b0;
        m_store_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = stray_rvalid;
        #2;
        checkOutput("idle_stall", 32'(stall_o), 32'd0);
        checkOutput("idle_req", 32'(data_req_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle_w_valid", 32'(w_valid_o), 32'd0);
    endtask

    initial begin
        logic [2:0] ld_ops [5];
        logic [2:0] st_ops [3];
        int         kind;
        logic [2:0] op;

        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_ops = '{3'b000, 3'b001, 3'b010};

        #2;
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_req", 32'(data_req_o), 32'd0);
        checkOutput("rst_wr", 32'(data_wr_o), 32'd0);
        checkOutput("rst_w_valid", 32'(w_valid_o), 32'd0);
        checkOutput("rst_w_wr", 32'(w_regfile_wr_o), 32'd0);
        checkOutput("rst_w_wdata", w_regfile_wdata_o, 32'd0);
        checkOutput("rst_w_err", 32'(w_bus_err_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1, 3'b010, 32'h0010, 32'hDEADBEEF, 32'h1111_0000, 5'd3, 1'b0, 0, 0, 32'h0, 1'b0);
        applyStimulus(1, 3'b000, 32'h0013, 32'h000000A5, 32'h2222_0000, 5'd4, 1'b0, 0, 0, 32'h0, 1'b0);
        applyStimulus(0, 3'b000, 32'h0022, 32'h0, 32'h0, 5'd5, 1'b1, 2, 0, 32'h12805634, 1'b0);
        applyStimulus(0, 3'b100, 32'h0022, 32'h0, 32'h0, 5'd6, 1'b1, 2, 0, 32'h12805634, 1'b0);
        applyStimulus(0, 3'b101, 32'h0002, 32'h0, 32'h0, 5'd7, 1'b1, 0, 1, 32'hBEEF1234, 1'b1);
        applyStimulus(1, 3'b001, 32'h0006, 32'h0000CAFE, 32'h0, 5'd8, 1'b0, 0, 0, 32'h0, 1'b0);
        applyStimulus(2, 3'b000, 32'h0, 32'h0, 32'h5A5A_0001, 5'd9, 1'b1, 0, 0, 32'h0, 1'b1);
        applyStimulus(0, 3'b010, 32'h0001, 32'h0, 32'h0, 5'd10, 1'b1, 1, 0, 32'h89AB_CDEF, 1'b0);
        applyIdle(1'b1);

        $display("[TB] random accesses");
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            op   = (kind == 1) ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            applyStimulus(kind, op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                          1'($urandom));
            if ($urandom_range(0, 3) == 0) applyIdle(1'($urandom));
        end

        $display("[TB] timeout abort");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            m_valid_i         = 1'b1;
            m_load_i          = 1'b1;
            m_store_i         = 1'b0;
            m_ls_op_i         = 3'b010;
            m_addr_i          = 32'h0040;
            m_regfile_waddr_i = 5'd12;
            m_regfile_wr_i    = 1'b1;
            data_gnt_i        = 1'b0;
            data_rvalid_i     = 1'b0;
            #2;
            checkOutput("tmo_stall", 32'(t_stall), 32'(k < 4));
            if (k < 4) checkOutput("tmo_req", 32'(t_req), 32'd1);
            @(posedge clk);
            #1;
            if (k < 4) checkOutput("tmo_bubble", 32'(t_w_valid), 32'd0);
        end
        checkOutput("tmo_w_valid", 32'(t_w_valid), 32'd1);
        checkOutput("tmo_w_err", 32'(t_w_err), 32'd1);
        checkOutput("tmo_w_wr", 32'(t_w_wr), 32'd0);
        checkOutput("tmo_w_waddr", 32'(t_w_waddr), 32'd12);

        @(negedge clk);
        m_valid_i     = 1'b0;
        m_load_i      = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        #2;
        checkOutput("late_rvalid_stall", 32'(t_stall), 32'd0);
        checkOutput("late_rvalid_req", 32'(t_req), 32'd0);
        checkOutput("held_req_main", 32'(data_req_o), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("late_rvalid_w_valid", 32'(t_w_valid), 32'd0);
        checkOutput("late_rvalid_w_err", 32'(t_w_err), 32'd0);

        @(negedge clk);
        data_rvalid_i = 1'b0;
        rst_n         = 1'b0;
        #2;
        checkOutput("midrst_req", 32'(data_req_o), 32'd0);
        checkOutput("midrst_w_valid", 32'(w_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyIdle(1'b1);
        applyStimulus(0, 3'b001, 32'h0036, 32'h0, 32'h0, 5'd13, 1'b1, 1, 2, 32'h8001_7FFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
